code2421_deframer: RTL and testbench

CODE2421_DEFRAMER -- requirements
Module: code2421_deframer

---
 rtl/code2421_deframer_pkg.sv | 18 +
 rtl/code2421_dec.sv | 15 +
 rtl/code2421_deframer.sv | 62 ++++++
 tb/tb_code2421_deframer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/code2421_deframer_pkg.sv
// code2421_deframer_pkg: shared FSM states, 2421 code table and invalid-code range
package code2421_deframer_pkg;
  typedef enum logic {COLLECT, PRESENT} state_e;
  localparam logic [3:0] CODE_0 = 4'b0000;
  localparam logic [3:0] CODE_1 = 4'b0001;
  localparam logic [3:0] CODE_2 = 4'b0010;
  localparam logic [3:0] CODE_3 = 4'b0011;
  localparam logic [3:0] CODE_4 = 4'b0100;
  localparam logic [3:0] CODE_5 = 4'b1011;
  localparam logic [3:0] CODE_6 = 4'b1100;
  localparam logic [3:0] CODE_7 = 4'b1101;
  localparam logic [3:0] CODE_8 = 4'b1110;
  localparam logic [3:0] CODE_9 = 4'b1111;
  localparam logic [3:0] CODE_TABLE [10] = '{CODE_0, CODE_1, CODE_2, CODE_3, CODE_4,
                                             CODE_5, CODE_6, CODE_7, CODE_8, CODE_9};
  localparam logic [3:0] INV_LO = 4'b0101;
  localparam logic [3:0] INV_HI = 4'b1010;
endpackage

// File: rtl/code2421_dec.sv
// code2421_dec: combinational 2421 to BCD digit decoder; invalid codes yield digit 0
module code2421_dec
  import code2421_deframer_pkg::*;
(
  input  logic [3:0] in_code,
  output logic [3:0] digit,
  output logic       invalid
);
  assign invalid = (in_code >= INV_LO) && (in_code <= INV_HI);
  always_comb begin
    digit = '0;
    for (int i = 0; i < 10; i++)
      if (in_code == CODE_TABLE[i]) digit = 4'(i);
  end
endmodule

// File: rtl/code2421_deframer.sv
// code2421_deframer: collects DIGITS 2421 words into a packed BCD frame with sticky error flag
module code2421_deframer
  import code2421_deframer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err
);
  localparam int FW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  state_e          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [FW-1:0]   frame;
  logic            err;
  logic [3:0]      digit;
  logic            invalid;
  logic            in_fire, out_fire, last;
  code2421_dec u_dec (
    .in_code (in_code),
    .digit   (digit),
    .invalid (invalid)
  );
  assign in_ready  = state == COLLECT;
  assign out_valid = state == PRESENT;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last      = cnt == CW'(DIGITS - 1);
  assign out_bcd   = frame;
  assign out_err   = err;
  always_comb begin
    state_nx = state;
    state_nx = (in_fire && last) ? PRESENT : out_fire ? COLLECT : state;
  end
  // in_fire and out_fire are mutually exclusive since they depend on opposite states
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      cnt   <= '0;
      frame <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (out_fire) begin
        cnt   <= '0;
        frame <= '0;
        err   <= 1'b0;
      end else if (in_fire) begin
        cnt   <= cnt + CW'(1);
        frame <= (frame << 4) | FW'(digit);
        err   <= err | invalid;
      end
    end
  end
endmodule

// File: tb/tb_code2421_deframer.sv
// tb_code2421_deframer: randomized and directed checks of the deframer against a table model
module tb_code2421_deframer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
  logic [3:0]  in_code = '0;
  logic [15:0] out_bcd;
  logic        r_in_valid = 1'b0, r_in_ready, r_out_valid, r_out_ready = 1'b0, r_out_err;
  logic [3:0]  r_in_code = '0, r_out_bcd;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  code2421_deframer #(.DIGITS(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_err(out_err));

  code2421_deframer #(.DIGITS(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready), .in_code(r_in_code),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_bcd(r_out_bcd), .out_err(r_out_err));

  function automatic logic [4:0] ref_dec(input logic [3:0] c);
    case (c)
      4'b0000: return {1'b0, 4'd0};
      4'b0001: return {1'b0, 4'd1};
      4'b0010: return {1'b0, 4'd2};
      4'b0011: return {1'b0, 4'd3};
      4'b0100: return {1'b0, 4'd4};
      4'b1011: return {1'b0, 4'd5};
      4'b1100: return {1'b0, 4'd6};
      4'b1101: return {1'b0, 4'd7};
      4'b1110: return {1'b0, 4'd8};
      4'b1111: return {1'b0, 4'd9};
      default: return {1'b1, 4'd0};
    endcase
  endfunction

  function automatic logic [16:0] ref_frame(input logic [3:0] c0, c1, c2, c3);
    logic [4:0] d0, d1, d2, d3;
    d0 = ref_dec(c0); d1 = ref_dec(c1); d2 = ref_dec(c2); d3 = ref_dec(c3);
    return {d0[4] | d1[4] | d2[4] | d3[4], d0[3:0], d1[3:0], d2[3:0], d3[3:0]};
  endfunction

  // called at a negedge; returns at the negedge after the word was taken
  task automatic send(input logic [3:0] c);
    int n = 0;
    in_valid = 1'b1;
    in_code  = c;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic take_frame(output logic [15:0] bcd, output logic e);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL frame_timeout: out_valid=%0b required 1", out_valid);
    end
    bcd = out_bcd;
    e   = out_err;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] c0, c1, c2, c3, input string name);
    logic [15:0] bcd;
    logic        e;
    logic [16:0] exp;
    exp = ref_frame(c0, c1, c2, c3);
    send(c0); send(c1); send(c2); send(c3);
    take_frame(bcd, e);
    checks++;
    if (bcd !== exp[15:0] || e !== exp[16]) begin
      errors++;
      $display("FAIL %s: bcd=%h err=%0b required bcd=%h err=%0b", name, bcd, e, exp[15:0], exp[16]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_bcd, out_err} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_d4: rdy=%0b vld=%0b bcd=%h err=%0b required 1 0 0000 0",
               in_ready, out_valid, out_bcd, out_err);
    end
    checks++;
    if ({r_in_ready, r_out_valid, r_out_bcd, r_out_err} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_d1: rdy=%0b vld=%0b bcd=%h err=%0b required 1 0 0 0",
               r_in_ready, r_out_valid, r_out_bcd, r_out_err);
    end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send(4'b0001); send(4'b1011); send(4'b1110);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: out_valid=%0b required 0", out_valid);
    end
    send(4'b0100);
    checks++;
    if ({out_valid, out_bcd, out_err} !== {1'b1, 16'h1584, 1'b0}) begin
      errors++;
      $display("FAIL basic_frame: vld=%0b bcd=%h err=%0b required 1 1584 0", out_valid, out_bcd, out_err);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_bcd} !== {1'b0, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL basic_clear: vld=%0b rdy=%0b bcd=%h required 0 1 0000", out_valid, in_ready, out_bcd);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_all_codes;
    send_frame(4'b0000, 4'b0001, 4'b0010, 4'b0011, "codes_f0");
    send_frame(4'b0100, 4'b1011, 4'b1100, 4'b1101, "codes_f1");
    send_frame(4'b1110, 4'b1111, 4'b0000, 4'b0000, "codes_f2");
  endtask

  task automatic test_error;
    send_frame(4'b0011, 4'b0110, 4'b1111, 4'b0000, "err_set");
    send_frame(4'b0000, 4'b0000, 4'b0000, 4'b0001, "err_clear");
    send_frame(4'b0101, 4'b1010, 4'b0111, 4'b1001, "err_all_invalid");
  endtask

  task automatic test_backpressure;
    logic [15:0] bcd;
    logic        e;
    out_ready = 1'b0;
    send(4'b1111); send(4'b1101); send(4'b0100); send(4'b0001);
    in_valid = 1'b1;
    in_code  = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready, out_valid, out_bcd} !== {1'b0, 1'b1, 16'h9741}) begin
        errors++;
        $display("FAIL hold_%0d: rdy=%0b vld=%0b bcd=%h required 0 1 9741", i, in_ready, out_valid, out_bcd);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_bcd} !== {1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL no_bypass: rdy=%0b vld=%0b bcd=%h required 1 0 0000", in_ready, out_valid, out_bcd);
    end
    send(4'b0010); send(4'b0001); send(4'b0010); send(4'b0011);
    take_frame(bcd, e);
    checks++;
    if (bcd !== 16'h2123 || e !== 1'b0) begin
      errors++;
      $display("FAIL pending_kept: bcd=%h err=%0b required 2123 0", bcd, e);
    end
  endtask

  task automatic test_reset_midframe;
    send(4'b0001); send(4'b0110);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_bcd, out_err} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: rdy=%0b vld=%0b bcd=%h err=%0b required 1 0 0000 0",
               in_ready, out_valid, out_bcd, out_err);
    end
    send_frame(4'b1111, 4'b1111, 4'b1111, 4'b1111, "after_reset_9999");
    send(4'b0011); send(4'b0011); send(4'b0011); send(4'b0011);
    out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_bcd} !== {1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL present_reset: rdy=%0b vld=%0b bcd=%h required 1 0 0000", in_ready, out_valid, out_bcd);
    end
  endtask

  // DIGITS=1 instance under random handshakes on both sides
  task automatic test_random_d1;
    logic [4:0] q[$];
    logic [4:0] exp;
    int sent = 0, got = 0, cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      if (!(r_in_valid && !r_in_ready)) begin
        r_in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
        r_in_code  = 4'($urandom_range(0, 15));
      end
      r_out_ready = $urandom_range(0, 2) != 0;
      if (r_in_valid && r_in_ready) begin
        q.push_back(ref_dec(r_in_code));
        sent++;
      end
      if (r_out_valid && r_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected: bcd=%h err=%0b required no frame", r_out_bcd, r_out_err);
        end else begin
          exp = q.pop_front();
          if ({r_out_err, r_out_bcd} !== exp) begin
            errors++;
            $display("FAIL rand_frame_%0d: bcd=%h err=%0b required bcd=%h err=%0b",
                     got, r_out_bcd, r_out_err, exp[3:0], exp[4]);
          end
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    r_in_valid = 1'b0;
    checks++;
    if (got != 1000) begin
      errors++;
      $display("FAIL rand_count: frames=%0d required 1000", got);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_all_codes;
    test_error;
    test_backpressure;
    test_reset_midframe;
    test_random_d1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
